// File: rtl/fb_pkg.sv
// Shared constants and FSM state type for the framebuffer writer.
// Frame geometry, pixel packing and framebuffer word-address width.
package fb_pkg;

  localparam int H_RES         = 800;
  localparam int V_RES         = 600;
  localparam int PIX_W         = 8;
  localparam int PIX_PER_WORD  = 4;
  localparam int WORDS_PER_ROW = H_RES / PIX_PER_WORD;
  localparam int FB_WORDS      = H_RES * V_RES / PIX_PER_WORD;
  localparam int ADDR_W        = 17;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } fb_state_t;

endpackage

// File: rtl/fb_pixel_packer.sv
// Packs in-order pixel results into 32-bit words and writes them out.
// Ports: clear/res_* in, res_ready/wr_* out, last_wr pulses on final write.
module fb_pixel_packer
  import fb_pkg::*;
#(
  parameter int WORDS = FB_WORDS,
  parameter int AW    = ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             res_valid,
  input  logic [PIX_W-1:0] res_pix,
  output logic             res_ready,
  output logic             wr_en,
  input  logic             wr_ready,
  output logic [AW-1:0]    wr_addr,
  output logic [31:0]      wr_data,
  output logic             last_wr
);

  localparam logic [AW-1:0] LAST = AW'(WORDS - 1);
  localparam logic [AW-1:0] PRE  = AW'(WORDS - 2);

  logic               armed;
  logic [1:0]         lane;
  logic [3*PIX_W-1:0] acc;
  logic               wr_fire;
  logic               res_fire;
  logic               load;
  logic               final_load;

  // armed drops once the frame's last word is assembled so that
  // stray results beyond the frame are never taken.
  assign res_ready  = armed & ~(wr_en & ~wr_ready);
  assign wr_fire    = wr_en & wr_ready;
  assign res_fire   = res_valid & res_ready;
  assign load       = res_fire & (lane == 2'd3);
  // A load with wr_en set implies that write retires this cycle.
  assign final_load = load &
    (wr_en ? (wr_addr == PRE) : (wr_addr == LAST));
  assign last_wr    = wr_fire & (wr_addr == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      lane    <= 2'd0;
      acc     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (clear) begin
      armed   <= 1'b1;
      lane    <= 2'd0;
      wr_addr <= '0;
    end else begin
      if (res_fire) begin
        lane <= lane + 2'd1;
        if (lane != 2'd3)
          acc[lane*PIX_W +: PIX_W] <= res_pix;
      end
      if (final_load)
        armed <= 1'b0;
      if (wr_fire)
        wr_addr <= (wr_addr == LAST) ? '0 : wr_addr + AW'(1);
      if (load) begin
        wr_en   <= 1'b1;
        wr_data <= {res_pix, acc};
      end else if (wr_fire) begin
        wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fb_frame_writer.sv
// Raster-scan coordinate generator and frame FSM for the framebuffer.
// Ports: start/busy/done control, req_* to engine, res_* back, wr_* to memory.
module fb_frame_writer
  import fb_pkg::*;
#(
  parameter int FRAME_W = H_RES,
  parameter int FRAME_H = V_RES,
  parameter int WADDR_W = ADDR_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_req_valid,
  input  logic               i_req_ready,
  output logic [15:0]        o_req_x,
  output logic [15:0]        o_req_y,
  input  logic               i_res_valid,
  output logic               o_res_ready,
  input  logic [PIX_W-1:0]   i_res_pix,
  output logic               o_wr_en,
  input  logic               i_wr_ready,
  output logic [WADDR_W-1:0] o_wr_addr,
  output logic [31:0]        o_wr_data
);

  localparam int WORDS = FRAME_W * FRAME_H / PIX_PER_WORD;
  localparam logic [15:0] X_LAST = 16'(FRAME_W - 1);
  localparam logic [15:0] Y_LAST = 16'(FRAME_H - 1);

  fb_state_t state;
  fb_state_t next;
  logic      req_fire;
  logic      last_px;
  logic      start_ok;
  logic      last_wr;

  assign req_fire = o_req_valid & i_req_ready;
  assign last_px  = (o_req_x == X_LAST) & (o_req_y == Y_LAST);
  assign start_ok = (state == IDLE) & i_start;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next;
  end

  always_comb begin
    next        = state;
    o_req_valid = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    unique case (state)
      IDLE: if (i_start) next = RUN;
      RUN: begin
        o_req_valid = 1'b1;
        o_busy      = 1'b1;
        if (req_fire && last_px) next = DRAIN;
      end
      DRAIN: begin
        o_busy = 1'b1;
        if (last_wr) next = DONE;
      end
      DONE: begin
        o_done = 1'b1;
        next   = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_req_x <= '0;
      o_req_y <= '0;
    end else if (start_ok) begin
      o_req_x <= '0;
      o_req_y <= '0;
    end else if (req_fire) begin
      if (o_req_x == X_LAST) begin
        o_req_x <= '0;
        o_req_y <= (o_req_y == Y_LAST) ? '0 : o_req_y + 16'd1;
      end else begin
        o_req_x <= o_req_x + 16'd1;
      end
    end
  end

  fb_pixel_packer #(
    .WORDS(WORDS),
    .AW   (WADDR_W)
  ) u_packer (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .clear    (start_ok),
    .res_valid(i_res_valid),
    .res_pix  (i_res_pix),
    .res_ready(o_res_ready),
    .wr_en    (o_wr_en),
    .wr_ready (i_wr_ready),
    .wr_addr  (o_wr_addr),
    .wr_data  (o_wr_data),
    .last_wr  (last_wr)
  );

endmodule

// File: tb/tb_fb_frame_writer.sv
// Randomized self-checking bench for fb_frame_writer on a 16x4 frame.
// Engine model answers pix = x + 16*y + salt; writes checked against raster map.
module tb_fb_frame_writer;

  localparam int FW    = 16;
  localparam int FH    = 4;
  localparam int NPIX  = FW * FH;
  localparam int WORDS = NPIX / 4;
  localparam int WPR   = FW / 4;
  localparam int AW    = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic          req_valid;
  logic          req_ready = 1'b0;
  logic [15:0]   req_x, req_y;
  logic          res_valid = 1'b0;
  logic          res_ready;
  logic [7:0]    res_pix = 8'd0;
  logic          wr_en;
  logic          wr_ready = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  int n_err = 0;
  int n_chk = 0;
  logic [7:0]  eng_q[$];
  logic [31:0] mem [0:WORDS-1];

  fb_frame_writer #(
    .FRAME_W(FW),
    .FRAME_H(FH),
    .WADDR_W(AW)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .o_busy     (busy),
    .o_done     (done),
    .o_req_valid(req_valid),
    .i_req_ready(req_ready),
    .o_req_x    (req_x),
    .o_req_y    (req_y),
    .i_res_valid(res_valid),
    .o_res_ready(res_ready),
    .i_res_pix  (res_pix),
    .o_wr_en    (wr_en),
    .i_wr_ready (wr_ready),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pixf(int x, int y, logic [7:0] salt);
    return 8'(x + 16 * y + int'(salt));
  endfunction

  function automatic logic [31:0] word_model(int w, logic [7:0] salt);
    logic [31:0] d;
    int p;
    d = '0;
    for (int k = 0; k < 4; k++) begin
      p = 4 * w + k;
      d[k*8 +: 8] = pixf(p % FW, p / FW, salt);
    end
    return d;
  endfunction

  task automatic zero_inputs();
    start     = 1'b0;
    req_ready = 1'b0;
    res_valid = 1'b0;
    wr_ready  = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctl"},
          {busy, done, req_valid, res_ready, wr_en, req_x, req_y}, '0);
    check({tag, "_wr"}, {wr_addr, wr_data}, '0);
  endtask

  task automatic run_frame(input int rp, input int sp, input int wp,
                           input bit stall10, input bit dbl_start,
                           input int abort_word, input logic [7:0] salt);
    int nreq = 0;
    int nwr = 0;
    int ndone = 0;
    int cyc = 0;
    int stall_left = 0;
    bit stalled_once = 0;
    bit last_acc = 0;
    bit finished = 0;
    bit prev_stall = 0;
    logic [AW-1:0] pa = '0;
    logic [31:0]   pd = '0;
    int p, ex;

    eng_q.delete();
    zero_inputs();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("req_latency", req_valid, 1'b1);
    check("busy_run", busy, 1'b1);

    while (!finished && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (done) ndone++;
      if (last_acc) begin
        check("done_latency", done, 1'b1);
        finished = 1;
        break;
      end
      if (prev_stall) begin
        check("stall_addr", wr_addr, pa);
        check("stall_data", wr_data, pd);
      end

      req_ready = ($urandom_range(0, 99) < rp);
      if (stall10 && wr_en && !stalled_once) begin
        stall_left   = 10;
        stalled_once = 1;
      end
      if (stall_left > 0) begin
        wr_ready = 1'b0;
        stall_left--;
      end else begin
        wr_ready = ($urandom_range(0, 99) < wp);
      end
      if (eng_q.size() > 0) begin
        res_valid = ($urandom_range(0, 99) < sp);
        res_pix   = eng_q[0];
      end else begin
        res_valid = 1'b0;
        res_pix   = 8'($urandom);
      end
      start = dbl_start && busy && (cyc % 17 == 0);
      #1;

      if (wr_en && !wr_ready)
        check("stall_res_ready", res_ready, 1'b0);
      prev_stall = wr_en && !wr_ready;
      pa = wr_addr;
      pd = wr_data;

      if (req_valid && req_ready) begin
        check("req_x", req_x, 64'(nreq % FW));
        check("req_y", req_y, 64'(nreq / FW));
        eng_q.push_back(pixf(int'(req_x), int'(req_y), salt));
        nreq++;
      end
      if (res_valid && res_ready)
        void'(eng_q.pop_front());
      if (wr_en && wr_ready) begin
        p  = 4 * nwr;
        ex = (p % FW) / 4 + (p / FW) * WPR;
        check("wr_addr", wr_addr, 64'(ex));
        check("wr_data", wr_data, word_model(nwr, salt));
        if (wr_addr < AW'(WORDS)) mem[wr_addr] = wr_data;
        nwr++;
        if (nwr == WORDS) last_acc = 1;
      end

      if (abort_word >= 0 && nwr == abort_word) begin
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outs("abort_rst");
        check("abort_no_done", ndone, 0);
        @(negedge clk);
        rst_n = 1'b1;
        zero_inputs();
        eng_q.delete();
        return;
      end
    end

    if (!finished) check("frame_timeout", 1'b0, 1'b1);
    check("req_count", nreq, NPIX);
    check("wr_count", nwr, WORDS);

    start     = 1'b0;
    req_ready = 1'b1;
    wr_ready  = 1'b1;
    res_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (done) ndone++;
      check("excess_res_ready", res_ready, 1'b0);
    end
    check("idle_busy", {busy, req_valid, wr_en}, 3'b000);
    check("done_count", ndone, 1);
    zero_inputs();
  endtask

  initial begin
    zero_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("por");
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(100, 100, 100, 0, 0, -1, 8'd0);
    check("t1_addr0", mem[0], 32'h03020100);
    check("t1_addr7", mem[7], 32'h1F1E1D1C);

    run_frame(50, 50, 50, 0, 0, -1, 8'($urandom));
    run_frame(100, 100, 100, 1, 0, -1, 8'($urandom));
    run_frame(100, 100, 100, 0, 0, 3, 8'd5);
    run_frame(100, 100, 100, 0, 0, -1, 8'd9);
    run_frame(70, 70, 70, 0, 1, -1, 8'($urandom));
    for (int f = 0; f < 3; f++)
      run_frame($urandom_range(20, 90), $urandom_range(20, 90),
                $urandom_range(20, 90), f[0], 0, -1, 8'($urandom));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
